// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu host: register offsets, status bits,
// host sequencer states and bus access phases.
package gpioemu_pkg;

    localparam logic [15:0] OFS_A1   = 16'h0000;
    localparam logic [15:0] OFS_A2   = 16'h0008;
    localparam logic [15:0] OFS_W    = 16'h0010;
    localparam logic [15:0] OFS_L    = 16'h0018;
    localparam logic [15:0] OFS_CTRL = 16'h0020;

    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_A1,
        ST_WR_A2,
        ST_WR_START,
        ST_POLL,
        ST_GAP,
        ST_RD_W,
        ST_RD_L,
        ST_RESP
    } host_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } bus_phase_e;

    // States that own a bus access while they are active.
    function automatic logic is_access_state(host_state_e s);
        logic r;
        case (s)
            ST_WR_A1, ST_WR_A2, ST_WR_START,
            ST_POLL, ST_RD_W, ST_RD_L: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpioemu_bus_access.sv
// One three-cycle register access (SETUP, STROBE, HOLD) toward the gpioemu
// peripheral. A start seen during HOLD chains the next access with no gap.
module gpioemu_bus_access
    import gpioemu_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic        rd,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in,
    output logic [31:0] rdata,
    output logic        done,
    output bus_phase_e  phase
);

    bus_phase_e phase_q;
    bus_phase_e phase_d;
    logic       rd_q;
    logic       load;

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE:   if (start) phase_d = PH_SETUP;
            PH_SETUP:  phase_d = PH_STROBE;
            PH_STROBE: phase_d = PH_HOLD;
            PH_HOLD:   phase_d = start ? PH_SETUP : PH_IDLE;
            default:   phase_d = PH_IDLE;
        endcase
    end

    assign load  = start && ((phase_q == PH_IDLE) || (phase_q == PH_HOLD));
    assign done  = (phase_q == PH_HOLD);
    assign rdata = sdata_in;
    assign phase = phase_q;

    // Strobes are registered so they are glitch-free and drop on reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q   <= PH_IDLE;
            rd_q      <= 1'b0;
            saddress  <= 16'h0000;
            sdata_out <= 32'h0000_0000;
            srd       <= 1'b0;
            swr       <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (load) begin
                saddress <= addr;
                rd_q     <= rd;
                if (!rd) sdata_out <= wdata;
            end
            srd <= (phase_q == PH_SETUP) && rd_q;
            swr <= (phase_q == PH_SETUP) && !rd_q;
        end
    end

endmodule

// File: rtl/gpioemu_host.sv
// Bus initiator that runs a complete gpioemu multiply job: write operands,
// start, poll status, read W and L, and hand the result back on a response port.
module gpioemu_host
    import gpioemu_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0380,
    parameter int          POLL_MAX  = 255,
    parameter int          POLL_GAP  = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_l,
    output logic        rsp_timeout,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in,
    output logic        busy,
    output logic [15:0] job_count
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid, once raised, holds its payload until that edge.

    host_state_e state_q;
    host_state_e state_d;
    logic [23:0] a1_q;
    logic [23:0] a2_q;
    logic [15:0] poll_cnt_q;
    logic [3:0]  gap_cnt_q;

    logic        bus_start;
    logic        bus_rd;
    logic [15:0] bus_ofs;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_done;
    bus_phase_e  bus_phase;

    logic        poll_done;
    logic        poll_last;
    logic        gap_last;
    logic        cmd_fire;
    logic        poll_end;

    assign poll_done = bus_rdata[STATUS_DONE_BIT];
    assign poll_last = (poll_cnt_q + 16'd1) == 16'(POLL_MAX);
    assign gap_last  = (gap_cnt_q == 4'(POLL_GAP - 1));
    assign cmd_fire  = cmd_valid && (state_q == ST_IDLE);
    assign poll_end  = (state_q == ST_POLL) && bus_done;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (cmd_valid) state_d = ST_WR_A1;
            ST_WR_A1:    if (bus_done) state_d = ST_WR_A2;
            ST_WR_A2:    if (bus_done) state_d = ST_WR_START;
            ST_WR_START: if (bus_done) state_d = ST_POLL;
            ST_POLL: begin
                if (bus_done) begin
                    if (poll_done)          state_d = ST_RD_W;
                    else if (poll_last)     state_d = ST_RESP;
                    else if (POLL_GAP == 0) state_d = ST_POLL;
                    else                    state_d = ST_GAP;
                end
            end
            ST_GAP:      if (gap_last) state_d = ST_POLL;
            ST_RD_W:     if (bus_done) state_d = ST_RD_L;
            ST_RD_L:     if (bus_done) state_d = ST_RESP;
            ST_RESP:     if (rsp_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // The access for the state being entered is launched one cycle early so
    // consecutive accesses run back to back; WR_A1 launches on its first cycle.
    always_comb begin
        bus_start = is_access_state(state_d) &&
                    (bus_done || (state_q == ST_GAP) ||
                     ((state_q == ST_WR_A1) && (bus_phase == PH_IDLE)));
        bus_rd    = 1'b1;
        bus_ofs   = OFS_CTRL;
        bus_wdata = 32'h0000_0000;
        case (state_d)
            ST_WR_A1: begin
                bus_rd    = 1'b0;
                bus_ofs   = OFS_A1;
                bus_wdata = {8'h00, a1_q};
            end
            ST_WR_A2: begin
                bus_rd    = 1'b0;
                bus_ofs   = OFS_A2;
                bus_wdata = {8'h00, a2_q};
            end
            ST_WR_START: begin
                bus_rd    = 1'b0;
                bus_ofs   = OFS_CTRL;
                bus_wdata = 32'h0000_0001;
            end
            ST_RD_W: bus_ofs = OFS_W;
            ST_RD_L: bus_ofs = OFS_L;
            default: bus_ofs = OFS_CTRL;
        endcase
        bus_addr = BASE_ADDR + bus_ofs;
    end

    gpioemu_bus_access u_bus (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (bus_start),
        .rd        (bus_rd),
        .addr      (bus_addr),
        .wdata     (bus_wdata),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_out (sdata_out),
        .sdata_in  (sdata_in),
        .rdata     (bus_rdata),
        .done      (bus_done),
        .phase     (bus_phase)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            a1_q        <= 24'h000000;
            a2_q        <= 24'h000000;
            poll_cnt_q  <= 16'h0000;
            gap_cnt_q   <= 4'h0;
            rsp_valid   <= 1'b0;
            rsp_w       <= 32'h0000_0000;
            rsp_l       <= 24'h000000;
            rsp_timeout <= 1'b0;
            job_count   <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                a1_q        <= cmd_a1;
                a2_q        <= cmd_a2;
                rsp_timeout <= 1'b0;
            end
            if ((state_q == ST_WR_START) && bus_done) poll_cnt_q <= 16'h0000;
            else if (poll_end)                        poll_cnt_q <= poll_cnt_q + 16'd1;
            if (poll_end)                gap_cnt_q <= 4'h0;
            else if (state_q == ST_GAP)  gap_cnt_q <= gap_cnt_q + 4'h1;
            // Status never reported done: answer with a zeroed result.
            if (poll_end && !poll_done && poll_last) begin
                rsp_timeout <= 1'b1;
                rsp_w       <= 32'h0000_0000;
                rsp_l       <= 24'h000000;
                rsp_valid   <= 1'b1;
            end
            if ((state_q == ST_RD_W) && bus_done) rsp_w <= bus_rdata;
            if ((state_q == ST_RD_L) && bus_done) begin
                rsp_l     <= bus_rdata[23:0];
                rsp_valid <= 1'b1;
            end
            if ((state_q == ST_RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                job_count <= job_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gpioemu_host.sv
// Bench for gpioemu_host: behavioural peripheral, timeline reference model
// built from the documented access latencies, and an access scoreboard.
module tb_gpioemu_host;

    localparam logic [15:0] BASE = 16'h0380;
    localparam int PMAX = 4;
    localparam int PGAP = 2;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_a1;
    logic [23:0] cmd_a2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic        rsp_timeout;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in = 32'h0;
    logic        busy;
    logic [15:0] job_count;

    gpioemu_host #(.BASE_ADDR(BASE), .POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
        .clk(clk), .n_reset(n_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a1(cmd_a1), .cmd_a2(cmd_a2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_w(rsp_w), .rsp_l(rsp_l),
        .rsp_timeout(rsp_timeout), .saddress(saddress), .srd(srd), .swr(swr),
        .sdata_out(sdata_out), .sdata_in(sdata_in), .busy(busy), .job_count(job_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int unsigned cyc_g = 0;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    assert property (@(posedge clk) !(srd && swr));

    // access record: {cycle, rd, address, write data}
    logic [80:0] acc_q[$];
    logic [80:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_jobs = 16'h0;

    // behavioural peripheral
    logic [23:0] p_a1 = 24'h0;
    logic [23:0] p_a2 = 24'h0;
    int          p_polls = 0;
    int          p_done_after = 1;
    logic [47:0] p_prod;

    always @(negedge clk) begin
        if (n_reset && swr) begin
            acc_q.push_back({32'(cyc_g), 1'b0, saddress, sdata_out});
            if (saddress == BASE) p_a1 = sdata_out[23:0];
            else if (saddress == BASE + 16'h08) p_a2 = sdata_out[23:0];
            else if (saddress == BASE + 16'h20 && sdata_out == 32'h1) p_polls = 0;
        end
        if (n_reset && srd) begin
            acc_q.push_back({32'(cyc_g), 1'b1, saddress, 32'h0});
            p_prod = {24'h0, p_a1} * {24'h0, p_a2};
            if (saddress == BASE + 16'h20) begin
                p_polls = p_polls + 1;
                sdata_in = (p_polls >= p_done_after) ? 32'h3 : 32'h1;
            end else if (saddress == BASE + 16'h10) begin
                sdata_in = p_prod[31:0];
            end else if (saddress == BASE + 16'h18) begin
                sdata_in = 32'($countones(p_prod[31:0]));
            end else begin
                sdata_in = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic chk(input string tag, input logic [80:0] got, input logic [80:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: one job, with optional response backpressure and a stray command
    task automatic run_job(input logic [23:0] a1, input logic [23:0] a2,
                           input int done_after, input int hold, input bit poke);
        int          t0;
        int          lat;
        int          exp_lat;
        int          s;
        int          npolls;
        int          n_acc;
        bit          ok;
        logic [47:0] prod;
        logic [31:0] ew;
        logic [23:0] el;
        acc_q.delete();
        exp_q.delete();
        p_done_after = done_after;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_a1 = a1;
        cmd_a2 = a2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc_g;
        cmd_valid = 1'b0;
        chk("busy_after_accept", {busy, cmd_ready}, 2'b10);

        lat = -1;
        for (int i = 1; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = cyc_g - t0;
                break;
            end
        end

        // reference timeline from the documented cycle counts
        ok = (done_after <= PMAX);
        npolls = ok ? done_after : PMAX;
        exp_q.push_back({32'(t0 + 2), 1'b0, BASE, 8'h00, a1});
        exp_q.push_back({32'(t0 + 5), 1'b0, BASE + 16'h08, 8'h00, a2});
        exp_q.push_back({32'(t0 + 8), 1'b0, BASE + 16'h20, 32'h1});
        s = 11;
        for (int i = 0; i < npolls; i++) begin
            s = 11 + i * (3 + PGAP);
            exp_q.push_back({32'(t0 + s), 1'b1, BASE + 16'h20, 32'h0});
        end
        if (ok) begin
            exp_q.push_back({32'(t0 + s + 3), 1'b1, BASE + 16'h10, 32'h0});
            exp_q.push_back({32'(t0 + s + 6), 1'b1, BASE + 16'h18, 32'h0});
            exp_lat = s + 8;
        end else begin
            exp_lat = s + 2;
        end
        prod = 48'(a1) * 48'(a2);
        ew = ok ? prod[31:0] : 32'h0;
        el = ok ? 24'($countones(prod[31:0])) : 24'h0;

        chk("rsp_latency", 81'(lat), 81'(exp_lat));
        chk("rsp_payload", {rsp_w, rsp_l, rsp_timeout}, {ew, el, !ok});

        for (int i = 0; i < hold; i++) begin
            if (poke && i == hold / 2) begin
                cmd_a1 = ~a1;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("hold_stable", {rsp_valid, cmd_ready, rsp_w, rsp_l, rsp_timeout},
                {1'b1, 1'b0, ew, el, !ok});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_jobs = exp_jobs + 16'd1;
        chk("rsp_handshake", {rsp_valid, cmd_ready, job_count}, {1'b0, 1'b1, exp_jobs});

        n_acc = acc_q.size();
        chk("access_count", 81'(n_acc), 81'(exp_q.size()));
        for (int i = 0; i < n_acc && i < exp_q.size(); i++) chk("access", acc_q[i], exp_q[i]);

        if (poke) begin
            repeat (5) @(posedge clk);
            #1;
            chk("stray_cmd_ignored", {busy, 32'(acc_q.size())}, {1'b0, 32'(n_acc)});
        end
    endtask

    task automatic reset_mid_job();
        int k;
        bit seen;
        p_done_after = 1;
        @(negedge clk);
        cmd_a1 = 24'd7;
        cmd_a2 = 24'd9;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k = 0;
        while (!(swr && saddress == BASE + 16'h08) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("reach_wr_a2_strobe", k < 30, 1'b1);
        n_reset = 1'b0;
        #1;
        chk("async_strobe_drop", {srd, swr}, 2'b00);
        chk("async_ctl_reset", {busy, cmd_ready, rsp_valid, job_count}, {1'b0, 1'b1, 1'b0, 16'h0});
        @(negedge clk);
        n_reset = 1'b1;
        exp_jobs = 16'h0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("no_rsp_after_reset", seen, 1'b0);
        chk("post_reset_idle", {cmd_ready, job_count}, {1'b1, 16'h0});
    endtask

    initial begin
        n_reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_a1 = 24'h0;
        cmd_a2 = 24'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus", {saddress, srd, swr, sdata_out}, 81'h0);
        chk("rst_rsp", {rsp_valid, rsp_w, rsp_l, rsp_timeout}, 81'h0);
        chk("rst_ctl", {cmd_ready, busy, job_count}, {1'b1, 1'b0, 16'h0});
        @(negedge clk);
        n_reset = 1'b1;

        run_job(24'd3, 24'd5, 1, 0, 1'b0);
        chk("basic_w_l", {rsp_w, rsp_l}, {32'h0000_000F, 24'd4});
        run_job(24'h000123, 24'h000456, 4, 1, 1'b0);
        run_job(24'h000011, 24'h000022, PMAX + 1, 0, 1'b0);
        run_job(24'hFFFFFF, 24'hFFFFFF, 1, 10, 1'b1);
        chk("backpressure_w_l", {rsp_w, rsp_l}, {32'hFE00_0001, 24'd8});
        reset_mid_job();

        for (int j = 0; j < 8; j++) begin
            run_job(24'($urandom), 24'($urandom_range(0, 4095)),
                    $urandom_range(1, PMAX + 1), $urandom_range(0, 3), 1'b0);
        end

        @(negedge clk);
        force dut.job_count = 16'hFFFF;
        @(negedge clk);
        release dut.job_count;
        exp_jobs = 16'hFFFF;
        run_job(24'd2, 24'd21, 2, 0, 1'b0);
        chk("job_count_wrap", job_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpioemu_host.md
Name: gpioemu_host

Overview:
- Bus initiator for the gpioemu register block; drives saddress/srd/swr/sdata toward the peripheral.
- Accepts a multiply job (A1, A2) on a valid/ready command port.
- Runs the full register sequence: write operands, write start, poll status, read W, read L.
- Returns W, L and a timeout flag on a valid/ready response port.
- Used by the testbench top and by on-chip sequencers that need the multiplier without software.

Parameters:
- BASE_ADDR, 16'h0380, peripheral base address. Offsets: +0x00 A1, +0x08 A2, +0x10 W, +0x18 L, +0x20 CTRL/STATUS.
- POLL_MAX, 255, maximum status reads before the job is declared timed out (1..65535).
- POLL_GAP, 2, idle cycles between consecutive status reads (0..15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_reset  in  1  asynchronous active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  host idle, can accept a job
- cmd_a1  in  24  first operand
- cmd_a2  in  24  second operand
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_w  out  32  W register value read back
- rsp_l  out  24  L register value read back (sdata_in[23:0])
- rsp_timeout  out  1  status never showed done within POLL_MAX polls
- saddress  out  16  bus address
- srd  out  1  read strobe
- swr  out  1  write strobe
- sdata_out  out  32  write data, to peripheral sdata_in
- sdata_in  in  32  read data, from peripheral sdata_out
- busy  out  1  job in progress (not IDLE)
- job_count  out  16  completed-response counter

Behaviour:
- Reset (async, immediate): saddress=0, srd=0, swr=0, sdata_out=0, rsp_valid=0, rsp_w=0, rsp_l=0, rsp_timeout=0, busy=0, job_count=0, cmd_ready=1, state=IDLE, poll counter=0.
- Bus access is exactly 3 cycles:
  - SETUP: saddress and sdata_out valid, strobe low.
  - STROBE: the selected strobe high for exactly 1 cycle.
  - HOLD: strobe low, address and data held.
  - Read data is captured on the clock edge ending HOLD.
  - srd and swr are never high together.
  - Between accesses, saddress and sdata_out keep their last value and strobes stay low.
- Operands are zero-extended to 32 bits on sdata_out. Start write data is 32'h1.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch operands and go to WR_A1.
  - WR_A1: write A1 at BASE+0x00, then WR_A2.
  - WR_A2: write A2 at BASE+0x08, then WR_START.
  - WR_START: write 1 at BASE+0x20, clear poll counter, then POLL.
  - POLL: read BASE+0x20 and increment the poll counter.
    - If captured bit1=1, go to RD_W.
    - Else, if poll counter equals POLL_MAX, set timeout and go to RESP with w=0, l=0.
    - Else go to GAP.
  - GAP: wait POLL_GAP cycles, then POLL. With POLL_GAP=0, the next SETUP follows HOLD directly.
  - RD_W: read BASE+0x10 into rsp_w, then RD_L.
  - RD_L: read BASE+0x18 into rsp_l, then RESP.
  - RESP: rsp_valid=1. Outputs are stable until rsp_ready. On the handshake, clear rsp_valid, increment job_count (wraps 16'hFFFF to 0), return to IDLE.
- cmd_ready=0 in every state except IDLE. cmd_valid outside IDLE is ignored, not queued.
- Command accepted in the same cycle rsp handshake completes: not possible, since cmd_ready only rises the cycle after the return to IDLE.
- Latency with no wait, counting the cmd handshake edge as cycle 0:
  - First swr high in cycle 2.
  - Start strobe in cycle 8.
  - First poll srd in cycle 11.
  - If the first poll sees done: rsp_valid rises in cycle 19.
  - Each extra poll adds 3+POLL_GAP cycles.
- Reset mid-operation: strobes drop asynchronously, the job is discarded with no response, and job_count is cleared.
- rsp_timeout is cleared at the next command accept.

Decomposition:
- Shared package gpioemu_pkg holds:
  - Offset constants OFS_A1, OFS_A2, OFS_W, OFS_L, OFS_CTRL.
  - STATUS_DONE_BIT=1.
  - The host state enum.
  - The bus phase enum (SETUP/STROBE/HOLD).
- One sub-module, gpioemu_bus_access:
  - Inputs: start, rd/wr select, address, wdata.
  - Outputs: saddress/srd/swr/sdata_out, rdata, done pulse at end of HOLD.
- The host FSM sequences that sub-module.

Test Plan:
- Basic job: behavioural peripheral model returns done on the first poll; cmd A1=3, A2=5.
  - Writes appear in order: 0x380 data 3, 0x388 data 5, 0x3A0 data 1.
  - Then one read of 0x3A0, then reads of 0x390 and 0x398.
  - rsp_w=32'h0000000F, rsp_l=4, rsp_timeout=0.
  - rsp_valid rises in cycle 19 and job_count becomes 1 after the handshake.
- Polling: model reports status 2'b01 for 3 polls then 2'b11; POLL_GAP=2.
  - Exactly 4 status reads occur, with 2 idle cycles between consecutive HOLD and SETUP.
  - rsp_valid rises in cycle 34.
- Timeout: POLL_MAX=4, status stuck at 2'b01.
  - Exactly 4 polls occur with no reads of 0x390 or 0x398.
  - rsp_timeout=1, rsp_w=0, rsp_l=0.
- Backpressure: hold rsp_ready=0 for 10 cycles with A1=A2=24'hFFFFFF and model W=32'hFE000001, L=8.
  - Outputs stay stable and cmd_ready stays 0.
  - A cmd_valid pulse during this window is ignored.
  - After rsp_ready=1, job_count increments once.
- Reset mid-job: assert n_reset low during the STROBE cycle of WR_A2.
  - srd=swr=0 within the same cycle, and cmd_ready=1 after release.
  - No rsp_valid occurs, and job_count=0.
- Counter wrap: preload 65535 jobs (or force the counter) and complete one more job.
  - job_count=0.
  - A strobe-overlap assertion never fires across all scenarios.
